nvdla_cmac_core_mac: RTL and testbench

Signed INT8 dot-product cell that sits directly downstream of the CMAC active-operand stage, one instance per kernel slot. Each cycle it consumes one activated data atom and the matching activated weight atom (ATOMC lanes each), multiplies lane-wise, reduces through a pipelined adder tree and emits one signed partial sum toward the accumulator (CACC). Lanes whose data or weight non-zero flag is clear are skipped (operand-isolated). A saturating per-cell lane-op counter supports performance monitoring.

---
 rtl/nvdla_cmac_core_mac.sv | 181 ++++++++++++++++++
 tb/tb_nvdla_cmac_core_mac.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_cmac_core_mac.sv
// nvdla_cmac_core_mac: signed INT8 dot-product cell (one kernel slot).
// Multiplies one data atom with one weight atom lane-wise and reduces
// the products through a pipelined adder tree into one partial sum.
// Lanes without both non-zero flags are operand-isolated to zero.
// Optional feature macro: NVDLA_CMAC_MAC_RETIMING_EN adds a register
// between the group reduce and the final reduce (latency 3 -> 4).
// Handshake: mac_out_pvld is a one-cycle valid with no ready; the
// consumer must take every valid cycle, and mac_out_stripe_end is
// meaningful only while mac_out_pvld is high.
module nvdla_cmac_core_mac #(
    parameter int ATOMC = 64,
    parameter int BPE   = 8,
    parameter int RES_W = 2*BPE + $clog2(ATOMC)
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [BPE*ATOMC-1:0]   dat_actv_data,
    input  logic [ATOMC-1:0]       dat_actv_nz,
    input  logic [ATOMC-1:0]       dat_actv_pvld,
    input  logic                   dat_actv_stripe_end,
    input  logic [BPE*ATOMC-1:0]   wt_actv_data,
    input  logic [ATOMC-1:0]       wt_actv_nz,
    input  logic [ATOMC-1:0]       wt_actv_pvld,
    input  logic                   perf_clr,
    output logic                   mac_out_pvld,
    output logic [RES_W-1:0]       mac_out_data,
    output logic                   mac_out_stripe_end,
    output logic [15:0]            perf_lane_ops
);

    localparam int PW = 2*BPE;              // product width
    localparam int GW = PW + 3;             // 8-lane group sum width
    localparam int NG = ATOMC / 8;          // number of groups
    localparam int CW = $clog2(ATOMC) + 1;  // popcount width

    logic                    w_in_vld;
    logic [ATOMC-1:0]        w_lane_en;
    logic [ATOMC-1:0][PW-1:0] w_prod;
    logic [CW-1:0]           w_pop;
    logic [NG-1:0][GW-1:0]   w_grp;
    logic [NG-1:0][GW-1:0]   w_fin_grp;
    logic                    w_fin_vld;
    logic                    w_fin_se;
    logic [RES_W-1:0]        w_sum;
    logic [16:0]             w_perf_sum;
    logic                    w_unused_pvld;

    logic [ATOMC-1:0][PW-1:0] r_prod;
    logic [NG-1:0][GW-1:0]   r_grp;
    logic                    r_v1, r_v2;
    logic                    r_se1, r_se2;
    logic                    r_out_vld;
    logic                    r_out_se;
    logic [RES_W-1:0]        r_out_data;
    logic [15:0]             r_perf;

    // Valid pins are replicated per lane upstream; only bit 0 carries meaning.
    assign w_unused_pvld = ^{dat_actv_pvld[ATOMC-1:1], wt_actv_pvld[ATOMC-1:1]};
    assign w_in_vld      = dat_actv_pvld[0] & wt_actv_pvld[0];
    assign w_lane_en     = {ATOMC{w_in_vld}} & dat_actv_nz & wt_actv_nz;

    // Lane products (isolated lanes forced to zero) and contributing-lane popcount.
    always_comb begin
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        logic [PW-1:0] full;
        w_pop = '0;
        for (int k = 0; k < ATOMC; k++) begin
            ax = {{BPE{dat_actv_data[BPE*k+BPE-1]}}, dat_actv_data[BPE*k +: BPE]};
            bx = {{BPE{wt_actv_data[BPE*k+BPE-1]}}, wt_actv_data[BPE*k +: BPE]};
            full = ax * bx;
            w_prod[k] = w_lane_en[k] ? full : '0;
            w_pop = w_pop + CW'(w_lane_en[k]);
        end
    end

    // Group reduce: sign-extended sum of each 8-lane slice of products.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            w_grp[g] = '0;
            for (int j = 0; j < 8; j++) begin
                w_grp[g] = w_grp[g] + {{3{r_prod[8*g+j][PW-1]}}, r_prod[8*g+j]};
            end
        end
    end

    // S1 product registers: data only, no reset, load on issue.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_in_vld) r_prod <= w_prod;
    end

    // S2 group-sum registers: data only, load when S1 holds a valid atom.
    always_ff @(posedge nvdla_core_clk) begin
        if (r_v1) r_grp <= w_grp;
    end

    // Valid / stripe_end shift pipe running alongside the datapath.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_v1  <= 1'b0;
            r_se1 <= 1'b0;
            r_v2  <= 1'b0;
            r_se2 <= 1'b0;
        end else begin
            r_v1  <= w_in_vld;
            r_se1 <= dat_actv_stripe_end & w_in_vld;
            r_v2  <= r_v1;
            r_se2 <= r_se1;
        end
    end

`ifdef NVDLA_CMAC_MAC_RETIMING_EN
    logic [NG-1:0][GW-1:0] r_grp_rt;
    logic                  r_v3;
    logic                  r_se3;

    // Retiming stage: group sums data-only, valid/stripe_end reset-able.
    always_ff @(posedge nvdla_core_clk) begin
        if (r_v2) r_grp_rt <= r_grp;
    end

    // Retiming stage control bits.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_v3  <= 1'b0;
            r_se3 <= 1'b0;
        end else begin
            r_v3  <= r_v2;
            r_se3 <= r_se2;
        end
    end

    assign w_fin_grp = r_grp_rt;
    assign w_fin_vld = r_v3;
    assign w_fin_se  = r_se3;
`else
    assign w_fin_grp = r_grp;
    assign w_fin_vld = r_v2;
    assign w_fin_se  = r_se2;
`endif

    // Final reduce: exact signed sum of all groups; cannot overflow RES_W.
    always_comb begin
        w_sum = '0;
        for (int g = 0; g < NG; g++) begin
            w_sum = w_sum + RES_W'($signed(w_fin_grp[g]));
        end
    end

    // Output stage: data holds its last value between valid pulses.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            r_out_vld  <= 1'b0;
            r_out_se   <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_out_vld <= w_fin_vld;
            r_out_se  <= w_fin_se;
            if (w_fin_vld) r_out_data <= w_sum;
        end
    end

    assign w_perf_sum = {1'b0, r_perf} + 17'(w_pop);

    // Saturating lane-op counter; clear takes priority over increment.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn || perf_clr) begin
            r_perf <= '0;
        end else if (w_perf_sum[16]) begin
            r_perf <= 16'hFFFF;
        end else begin
            r_perf <= w_perf_sum[15:0];
        end
    end

    assign mac_out_pvld       = r_out_vld;
    assign mac_out_data       = r_out_data;
    assign mac_out_stripe_end = r_out_se;
    assign perf_lane_ops      = r_perf;

endmodule

// File: tb/tb_nvdla_cmac_core_mac.sv
// Self-checking bench for nvdla_cmac_core_mac: directed atoms, expected
// partial sums queued at issue and popped by an output monitor.
module tb_nvdla_cmac_core_mac;

  localparam int ATOMC = 64;
  localparam int BPE   = 8;
  localparam int RES_W = 2*BPE + $clog2(ATOMC);
  localparam int DW    = BPE*ATOMC;
`ifdef NVDLA_CMAC_MAC_RETIMING_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int EW = 32 + 1 + RES_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]    d_data = '0;
  logic [DW-1:0]    w_data = '0;
  logic [ATOMC-1:0] d_nz = '0;
  logic [ATOMC-1:0] w_nz = '0;
  logic [ATOMC-1:0] d_pvld = '0;
  logic [ATOMC-1:0] w_pvld = '0;
  logic             d_se = 1'b0;
  logic             p_clr = 1'b0;

  logic             out_pvld;
  logic [RES_W-1:0] out_data;
  logic             out_se;
  logic [15:0]      perf;

  nvdla_cmac_core_mac #(.ATOMC(ATOMC), .BPE(BPE)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .dat_actv_data       (d_data),
    .dat_actv_nz         (d_nz),
    .dat_actv_pvld       (d_pvld),
    .dat_actv_stripe_end (d_se),
    .wt_actv_data        (w_data),
    .wt_actv_nz          (w_nz),
    .wt_actv_pvld        (w_pvld),
    .perf_clr            (p_clr),
    .mac_out_pvld        (out_pvld),
    .mac_out_data        (out_data),
    .mac_out_stripe_end  (out_se),
    .perf_lane_ops       (perf)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [RES_W-1:0] model(input logic [DW-1:0] dd, input logic [DW-1:0] ww,
                                             input logic [ATOMC-1:0] dn, input logic [ATOMC-1:0] wn);
    int s;
    int a;
    int b;
    s = 0;
    for (int k = 0; k < ATOMC; k++) begin
      if (dn[k] && wn[k]) begin
        a = $signed(dd[BPE*k +: BPE]);
        b = $signed(ww[BPE*k +: BPE]);
        s = s + a * b;
      end
    end
    return RES_W'(s);
  endfunction

  function automatic logic [DW-1:0] rep(input logic [7:0] v);
    return {ATOMC{v}};
  endfunction

  // Output monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (out_pvld === 1'b1) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(out_data), 32'hDEAD_0000);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[RES_W-1:0]));
        chk("out_stripe_end", 32'(out_se), 32'(e[RES_W]));
        chk("out_cycle", 32'(cyc), e[EW-1:RES_W+1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [DW-1:0] dd, input logic [DW-1:0] ww,
                       input logic [ATOMC-1:0] dn, input logic [ATOMC-1:0] wn,
                       input logic dv, input logic wv, input logic se,
                       input logic clr, input logic push);
    int due;
    @(negedge clk);
    d_data = dd;
    w_data = ww;
    d_nz   = dn;
    w_nz   = wn;
    d_pvld = {ATOMC{dv}};
    w_pvld = {ATOMC{wv}};
    d_se   = se;
    p_clr  = clr;
    due    = cyc + LAT;
    if (dv && wv && push) exp_q.push_back({due[31:0], se, model(dd, ww, dn, wn)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      d_pvld = '0;
      w_pvld = '0;
      d_se   = 1'b0;
      p_clr  = 1'b0;
      d_data = {ATOMC{8'hA5}};
    end
  endtask

  localparam logic [ATOMC-1:0] ALL = {ATOMC{1'b1}};

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] dd;
    logic [DW-1:0] ww;
    int pulses0;

    repeat (3) @(negedge clk);
    chk("rst_pvld", 32'(out_pvld), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_se", 32'(out_se), 0);
    chk("rst_perf", 32'(perf), 0);
    rstn = 1'b1;
    idle(2);

    // full-lane -128 x -128
    issue(rep(8'h80), rep(8'h80), ALL, ALL, 1, 1, 0, 0, 1);
    chk("model_s1", 32'(model(rep(8'h80), rep(8'h80), ALL, ALL)), 32'(22'd1048576));
    idle(1);
    chk("perf_64", 32'(perf), 64);
    idle(5);

    // data 1 x weight -1 on low 32 lanes; high lanes garbage, weight nz off
    dd = rep(8'h01);
    ww = rep(8'hFF);
    for (int k = 32; k < ATOMC; k++) begin
      dd[8*k +: 8] = 8'($urandom_range(0, 255));
      ww[8*k +: 8] = 8'($urandom_range(0, 255));
    end
    issue(dd, ww, ALL, {32'h0, 32'hFFFF_FFFF}, 1, 1, 0, 0, 1);
    chk("model_s2", 32'(model(dd, ww, ALL, {32'h0, 32'hFFFF_FFFF})), 32'(22'h3FFFE0));
    idle(1);
    chk("perf_96", 32'(perf), 96);

    // valid with every lane skipped -> zero sum
    issue(rep(8'h7F), rep(8'h7F), '0, ALL, 1, 1, 0, 0, 1);
    // extreme negative: -128 x 127 on all lanes = -1040384
    issue(rep(8'h80), rep(8'h7F), ALL, ALL, 1, 1, 0, 0, 1);
    // mixed signs and sparse flags
    for (int k = 0; k < ATOMC; k++) begin
      dd[8*k +: 8] = 8'(k - 32);
      ww[8*k +: 8] = (k % 2 == 1) ? 8'hFB : 8'h03;
    end
    issue(dd, ww, 64'hF0F0_A5A5_FFFF_0F0F, 64'hFFFF_0000_FFFF_FFFF, 1, 1, 0, 0, 1);
    idle(6);

    // data valid without weight valid -> no output
    pulses0 = n_pulse;
    issue(rep(8'h11), rep(8'h22), ALL, ALL, 1, 0, 1, 0, 1);
    idle(6);
    chk("no_pulse_wt_invalid", 32'(n_pulse - pulses0), 0);

    // 10 back-to-back atoms, stripe_end on the last
    pulses0 = n_pulse;
    for (int i = 0; i < 10; i++) begin
      issue(rep(8'(i + 1)), rep(8'h02), ALL, ALL, 1, 1, (i == 9), 0, 1);
    end
    idle(6);
    chk("b2b_pulses", 32'(n_pulse - pulses0), 10);

    // reset one cycle after two valid inputs: both discarded
    pulses0 = n_pulse;
    issue(rep(8'h05), rep(8'h05), ALL, ALL, 1, 1, 0, 0, 0);
    issue(rep(8'h06), rep(8'h06), ALL, ALL, 1, 1, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b0;
    d_pvld = '0;
    w_pvld = '0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_pvld", 32'(out_pvld), 0);
      chk("midrst_data", 32'(out_data), 0);
      chk("midrst_se", 32'(out_se), 0);
      chk("midrst_perf", 32'(perf), 0);
    end
    rstn = 1'b1;
    idle(8);
    chk("midrst_no_pulse", 32'(n_pulse - pulses0), 0);

    // 1100 full-lane atoms: 70400 lane-ops saturate the counter
    for (int i = 0; i < 1100; i++) begin
      issue(rep(8'h01), rep(8'h01), ALL, ALL, 1, 1, 0, 0, 1);
    end
    idle(1);
    chk("perf_sat", 32'(perf), 32'hFFFF);
    idle(2);
    chk("perf_sat_hold", 32'(perf), 32'hFFFF);

    // clear with a simultaneous full atom -> 0
    issue(rep(8'h01), rep(8'h01), ALL, ALL, 1, 1, 0, 1, 1);
    idle(1);
    chk("perf_clr", 32'(perf), 0);
    issue(rep(8'h01), rep(8'h01), ALL, ALL, 1, 1, 0, 0, 1);
    idle(1);
    chk("perf_after_clr", 32'(perf), 64);

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("queue_drained", 32'(exp_q.size()), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
